// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and sync helpers. The renderer pulls
// the same sync boundaries and totals from here for its sprite windows.
package vga_pkg;

  // Default horizontal timing, in pixel clocks.
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

  // Full raster dimensions for the default mode.
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT_PORCH +
                           DEF_H_SYNC_PULSE + DEF_H_BACK_PORCH;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT_PORCH +
                           DEF_V_SYNC_PULSE + DEF_V_BACK_PORCH;

  // Sync windows: start inclusive, end exclusive.
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT_PORCH;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC_PULSE;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT_PORCH;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC_PULSE;

  // Output shaping defaults.
  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;
  localparam int DEF_PIPE_DELAY      = 1;
  localparam int MAX_PIPE_DELAY      = 4;
  localparam int DEF_FRAME_BITS      = 5;

  // The sync pair travels together through the delay line.
  localparam int SYNC_W = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_pair_t;

  // Map a logical "sync asserted" flag onto the pin level.
  function automatic logic sync_level(input logic asserted, input bit active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that lags the sync pair behind the beam
// position so it lines up with the renderer's pixel pipeline.
// DEPTH is expected in 0..MAX_PIPE_DELAY; DEPTH = 0 is a straight wire.
module sync_delay
  import vga_pkg::*;
#(
  parameter int                DEPTH   = DEF_PIPE_DELAY,
  parameter int                WIDTH   = SYNC_W,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next stage contents: new sample enters stage 0, the rest shift along.
    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Stage registers; reset flushes every stage so no stale pulse leaks out.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: beam position, display enable, line
// and frame strobes, an animation frame counter, and syncs lagged to match
// the downstream pixel pipeline. Every output comes straight from a flop.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE    = DEF_H_SYNC_PULSE,
  parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE    = DEF_V_SYNC_PULSE,
  parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int PIPE_DELAY      = DEF_PIPE_DELAY,
  parameter int FRAME_BITS      = DEF_FRAME_BITS,
  localparam int H_PERIOD = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_PERIOD = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int X_BITS   = $clog2(H_PERIOD),
  localparam int Y_BITS   = $clog2(V_PERIOD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [X_BITS-1:0]     pixel_x,
  output logic [Y_BITS-1:0]     pixel_y,
  output logic                  active,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  hsync,
  output logic                  vsync
);

  // Sync windows for this instance's geometry (start inclusive, end exclusive).
  localparam int HS_BEGIN = H_ACTIVE + H_FRONT_PORCH;
  localparam int HS_END   = HS_BEGIN + H_SYNC_PULSE;
  localparam int VS_BEGIN = V_ACTIVE + V_FRONT_PORCH;
  localparam int VS_END   = VS_BEGIN + V_SYNC_PULSE;

  // Pin level while no sync pulse is in progress.
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  // Beam position and frame counter.
  logic [X_BITS-1:0]     x_q, x_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic [FRAME_BITS-1:0] frame_count_q, frame_count_d;

  // Position-aligned decodes, registered alongside the position itself.
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  sync_pair_t sync_q, sync_d;

  logic x_wrap;
  logic y_wrap;
  logic hs_on;
  logic vs_on;

  logic [SYNC_W-1:0] sync_lagged;

  // Advance the beam and decode the flags for the position it moves to, so
  // the registered flags describe the same pixel as the registered position.
  always_comb begin
    x_wrap        = (int'(x_q) == H_PERIOD - 1);
    y_wrap        = (int'(y_q) == V_PERIOD - 1);
    x_d           = x_q + X_BITS'(1);
    y_d           = y_q;
    frame_count_d = frame_count_q;

    if (x_wrap) begin
      x_d = '0;
      if (y_wrap) begin
        y_d           = '0;
        frame_count_d = frame_count_q + FRAME_BITS'(1);
      end else begin
        y_d = y_q + Y_BITS'(1);
      end
    end

    active_d      = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    line_start_d  = (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);

    hs_on = (int'(x_d) >= HS_BEGIN) && (int'(x_d) < HS_END);
    vs_on = (int'(y_d) >= VS_BEGIN) && (int'(y_d) < VS_END);

    sync_d.hsync = sync_level(hs_on, SYNC_ACTIVE_LOW);
    sync_d.vsync = sync_level(vs_on, SYNC_ACTIVE_LOW);
  end

  // Raster state; reset parks the beam on the first pixel of a fresh frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      sync_q        <= '{hsync: SYNC_IDLE, vsync: SYNC_IDLE};
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  // Lag the sync pair so it meets the renderer's pixels at the PMOD.
  sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (SYNC_W),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_q),
    .dout  (sync_lagged)
  );

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign hsync       = sync_lagged[1];
  assign vsync       = sync_lagged[0];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default mode, default lines with a
// short frame and inverted/3-deep syncs, and a tiny 14x7 raster with 4-deep
// syncs), each compared every cycle against a cycle-count model, plus
// table vectors and hand sequences for the edges and resets.
module tb_vga_timing;

  typedef logic [44:0] obs_t;

  typedef struct {
    int n;
    int x;
    int y;
    bit act;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
    int fc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def_n;
  logic rst_vs_n;
  logic rst_sm_n;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT signals ----------------
  logic [9:0] def_x, def_y;
  logic       def_act, def_ls, def_fs, def_hs, def_vs;
  logic [4:0] def_fc;

  logic [9:0] vs_x;
  logic [2:0] vs_y;
  logic       vs_act, vs_ls, vs_fs, vs_hs, vs_vs;
  logic [4:0] vs_fc;

  logic [3:0] sm_x;
  logic [2:0] sm_y;
  logic       sm_act, sm_ls, sm_fs, sm_hs, sm_vs;
  logic [4:0] sm_fc;

  vga_timing u_def (
    .clk(clk), .rst_n(rst_def_n), .pixel_x(def_x), .pixel_y(def_y),
    .active(def_act), .line_start(def_ls), .frame_start(def_fs),
    .frame_count(def_fc), .hsync(def_hs), .vsync(def_vs)
  );

  vga_timing #(
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .SYNC_ACTIVE_LOW(1'b0), .PIPE_DELAY(3)
  ) u_vs (
    .clk(clk), .rst_n(rst_vs_n), .pixel_x(vs_x), .pixel_y(vs_y),
    .active(vs_act), .line_start(vs_ls), .frame_start(vs_fs),
    .frame_count(vs_fc), .hsync(vs_hs), .vsync(vs_vs)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(2), .H_BACK_PORCH(2),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .PIPE_DELAY(4)
  ) u_sm (
    .clk(clk), .rst_n(rst_sm_n), .pixel_x(sm_x), .pixel_y(sm_y),
    .active(sm_act), .line_start(sm_ls), .frame_start(sm_fs),
    .frame_count(sm_fc), .hsync(sm_hs), .vsync(sm_vs)
  );

  // ---------------- reference model ----------------
  function automatic obs_t pack(input int x, input int y, input int fc,
                                input bit act, input bit ls, input bit fs,
                                input bit hs, input bit vs);
    return {16'(x), 16'(y), 8'(fc), act, ls, fs, hs, vs};
  endfunction

  // n = clock edges since the beam was last parked at the origin.
  function automatic obs_t model(input int n,
                                 input int ha, input int hf, input int hp, input int hb,
                                 input int va, input int vf, input int vp, input int vb,
                                 input int dly, input bit act_low, input int fbits);
    int ht, vt, x, y, fc, m, mx, my;
    bit hs_on, vs_on;
    ht = ha + hf + hp + hb;
    vt = va + vf + vp + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    fc = (n / (ht * vt)) % (1 << fbits);
    hs_on = 1'b0;
    vs_on = 1'b0;
    m = n - dly;
    if (m >= 0) begin
      mx = m % ht;
      my = (m / ht) % vt;
      hs_on = (mx >= ha + hf) && (mx < ha + hf + hp);
      vs_on = (my >= va + vf) && (my < va + vf + vp);
    end
    return pack(x, y, fc, (x < ha) && (y < va), x == 0, (x == 0) && (y == 0),
                act_low ? !hs_on : hs_on, act_low ? !vs_on : vs_on);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_obs(input string name, input int n, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name, input bit expired);
    checks++;
    if (expired) begin
      errors++;
      $display("FAIL %s wait budget expired", name);
    end
  endtask

  // Cycle counters since each instance's last reset cycle.
  int n_def, n_vs, n_sm;
  bit live_def = 1'b0, live_vs = 1'b0, live_sm = 1'b0;

  always @(posedge clk) begin
    if (!rst_def_n) begin n_def <= 0; live_def <= 1'b1; end else n_def <= n_def + 1;
    if (!rst_vs_n)  begin n_vs  <= 0; live_vs  <= 1'b1; end else n_vs  <= n_vs + 1;
    if (!rst_sm_n)  begin n_sm  <= 0; live_sm  <= 1'b1; end else n_sm  <= n_sm + 1;
  end

  // Every cycle, every instance against the model.
  always @(negedge clk) begin
    if (live_def)
      check_obs("model_def", n_def,
                pack(int'(def_x), int'(def_y), int'(def_fc), def_act, def_ls, def_fs, def_hs, def_vs),
                model(n_def, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1, 5));
    if (live_vs)
      check_obs("model_vs", n_vs,
                pack(int'(vs_x), int'(vs_y), int'(vs_fc), vs_act, vs_ls, vs_fs, vs_hs, vs_vs),
                model(n_vs, 640, 16, 96, 48, 4, 1, 2, 1, 3, 1'b0, 5));
    if (live_sm)
      check_obs("model_sm", n_sm,
                pack(int'(sm_x), int'(sm_y), int'(sm_fc), sm_act, sm_ls, sm_fs, sm_hs, sm_vs),
                model(n_sm, 8, 2, 2, 2, 4, 1, 1, 1, 4, 1'b1, 5));
  end

  // ---------------- directed + random stimulus ----------------
  vec_t vecs[$];

  initial begin
    int guard;
    int exp_fc;
    int fc0;
    int hcount, vcount;

    // Default-mode vectors: active-low syncs lagging position by one cycle.
    vecs.push_back('{0,    0,   0, 1, 1, 1, 1, 1, 0});
    vecs.push_back('{1,    1,   0, 1, 0, 0, 1, 1, 0});
    vecs.push_back('{639,  639, 0, 1, 0, 0, 1, 1, 0});
    vecs.push_back('{640,  640, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{656,  656, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{657,  657, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{752,  752, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{753,  753, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{799,  799, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{800,  0,   1, 1, 1, 0, 1, 1, 0});
    vecs.push_back('{801,  1,   1, 1, 0, 0, 1, 1, 0});
    vecs.push_back('{1457, 657, 1, 0, 0, 0, 0, 1, 0});

    rst_def_n = 1'b0;
    rst_vs_n  = 1'b0;
    rst_sm_n  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, then release everything together.
    check_obs("vec0_reset", 0,
              pack(int'(def_x), int'(def_y), int'(def_fc), def_act, def_ls, def_fs, def_hs, def_vs),
              pack(vecs[0].x, vecs[0].y, vecs[0].fc, vecs[0].act, vecs[0].ls, vecs[0].fs,
                   vecs[0].hs, vecs[0].vs));
    rst_def_n = 1'b1;
    rst_vs_n  = 1'b1;
    rst_sm_n  = 1'b1;

    for (int i = 1; i < vecs.size(); i++) begin
      guard = 0;
      while (n_def < vecs[i].n && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      timeout($sformatf("vec%0d_wait", i), guard >= 2000);
      check_obs($sformatf("vec%0d", i), vecs[i].n,
                pack(int'(def_x), int'(def_y), int'(def_fc), def_act, def_ls, def_fs, def_hs, def_vs),
                pack(vecs[i].x, vecs[i].y, vecs[i].fc, vecs[i].act, vecs[i].ls, vecs[i].fs,
                     vecs[i].hs, vecs[i].vs));
    end

    // Default mode: reset mid-frame at (300,2).
    guard = 0;
    while (n_def < 1900 && guard < 2000) begin @(negedge clk); guard++; end
    timeout("def_mid_wait", guard >= 2000);
    check_int("def_mid_x", int'(def_x), 300);
    check_int("def_mid_y", int'(def_y), 2);
    rst_def_n = 1'b0;
    @(negedge clk);
    check_obs("def_mid_reset", 0,
              pack(int'(def_x), int'(def_y), int'(def_fc), def_act, def_ls, def_fs, def_hs, def_vs),
              pack(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    rst_def_n = 1'b1;
    @(negedge clk);
    check_int("def_release_x", int'(def_x), 1);
    check_int("def_release_fs", int'(def_fs), 0);

    // Small raster: 32 frame wraps, counter rolls 31 -> 0.
    rst_sm_n = 1'b0;
    @(negedge clk);
    rst_sm_n = 1'b1;
    @(negedge clk);
    exp_fc = 0;
    for (int f = 0; f < 32; f++) begin
      guard = 0;
      while (!sm_fs && guard < 200) begin @(negedge clk); guard++; end
      timeout($sformatf("sm_frame%0d_wait", f), guard >= 200);
      exp_fc = (exp_fc + 1) % 32;
      check_int($sformatf("sm_frame%0d_fc", f), int'(sm_fc), exp_fc);
      check_int($sformatf("sm_frame%0d_ls", f), int'(sm_ls), 1);
      @(negedge clk);
    end
    check_int("sm_fc_rolled", int'(sm_fc), 0);

    // Small raster: reset while inside the hsync window with frame_count 7.
    guard = 0;
    while (!(int'(sm_fc) == 7 && int'(sm_x) == 11 && int'(sm_y) == 2) && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    timeout("sm_mid_wait", guard >= 1500);
    rst_sm_n = 1'b0;
    @(negedge clk);
    check_obs("sm_mid_reset", 0,
              pack(int'(sm_x), int'(sm_y), int'(sm_fc), sm_act, sm_ls, sm_fs, sm_hs, sm_vs),
              pack(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    rst_sm_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_int($sformatf("sm_no_stale_hs%0d", k), int'(sm_hs), 1);
      check_int($sformatf("sm_no_stale_x%0d", k), int'(sm_x), k);
    end

    // Inverted, 3-deep syncs: edges land 3 cycles after the window edges.
    guard = 0;
    while (int'(vs_x) != 658 && guard < 900) begin @(negedge clk); guard++; end
    timeout("vs_hs_rise_wait", guard >= 900);
    check_int("vs_hs_before", int'(vs_hs), 0);
    @(negedge clk);
    check_int("vs_hs_at_659", int'(vs_hs), 1);
    guard = 0;
    while (int'(vs_x) != 754 && guard < 900) begin @(negedge clk); guard++; end
    timeout("vs_hs_fall_wait", guard >= 900);
    check_int("vs_hs_at_754", int'(vs_hs), 1);
    @(negedge clk);
    check_int("vs_hs_at_755", int'(vs_hs), 0);

    // One full frame of the short-frame instance: sync pulse widths and the wrap.
    guard = 0;
    while (!vs_fs && guard < 7000) begin @(negedge clk); guard++; end
    timeout("vs_frame_wait", guard >= 7000);
    fc0 = int'(vs_fc);
    hcount = 0;
    vcount = 0;
    for (int c = 0; c < 6400; c++) begin
      if (vs_hs) hcount++;
      if (vs_vs) vcount++;
      @(negedge clk);
    end
    check_int("vs_vsync_cycles", vcount, 1600);
    check_int("vs_hsync_cycles", hcount, 768);
    check_int("vs_wrap_fs", int'(vs_fs), 1);
    check_int("vs_wrap_fc", int'(vs_fc), (fc0 + 1) % 32);

    // Random reset pulses on the small raster; the model checks every cycle.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 250)) @(negedge clk);
      rst_sm_n = 1'b0;
      if ($urandom_range(0, 1) == 1) rst_vs_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_sm_n = 1'b1;
      rst_vs_n = 1'b1;
    end
    repeat (300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
